dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Arbiter that shares the single-port data memory between the pipelined core's MEM stage and a debug/loader port. The core has priority by default. A starvation counter guarantees the debug port gets a slot within a bounded number of cycles. The block sits between the core's MemWriteM/ALU_result/Write_Data/Read_Data bus and the data memory, and raises a stall to the core's hazard unit when it takes the memory away.

Parameters:
ADDR_WIDTH, 32, width of memory address buses
DATA_WIDTH, 32, width of memory data buses
STARVE_LIMIT, 8, cycles a blocked debug request waits before it preempts the core (0 = debug wins at the next edge)
CNT_WIDTH, 4, starvation counter width; must hold STARVE_LIMIT

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  synchronous reset, active-low
core_req  in  1  core MEM stage performs a load or store this cycle
core_we  in  1  core store enable (MemWriteM)
core_addr  in  ADDR_WIDTH  core address (ALU_result)
core_wdata  in  DATA_WIDTH  core store data
core_rdata  out  DATA_WIDTH  load data to core
core_stall  out  1  freeze core pipeline; core holds its request
dbg_req  in  1  debug request, held high until dbg_ack
dbg_we  in  1  debug write enable
dbg_addr  in  ADDR_WIDTH  debug address
dbg_wdata  in  DATA_WIDTH  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_WIDTH  registered debug read data, valid with dbg_ack
mem_WE  out  1  data memory write enable
mem_Address  out  ADDR_WIDTH  data memory address
mem_WD  out  DATA_WIDTH  data memory write data
mem_RD  in  DATA_WIDTH  data memory combinational read data

Behaviour:
- FSM states: CORE, DBG_ACC, DBG_ACK. Reset state is CORE.
- Reset values: starve_cnt=0, dbg_ack=0, dbg_rdata=0, core_stall=0. While RST=0, mem_WE is forced to 0 and the bus mux selects core.
- CORE: memory bus = core signals. mem_WE = core_req & core_we. core_rdata = mem_RD. core_stall = 0.
  - If dbg_req & core_req: starve_cnt increments, saturating at 2^CNT_WIDTH-1.
  - If dbg_req & (!core_req | starve_cnt >= STARVE_LIMIT): next state is DBG_ACC.
- DBG_ACC (exactly 1 cycle):
  - Memory bus = debug signals; mem_WE = dbg_we.
  - core_stall = core_req; core_rdata is don't-care.
  - At the edge: the debug write commits in memory, dbg_rdata <= mem_RD (reads only; holds on writes), starve_cnt <= 0. Next state is DBG_ACK.
- DBG_ACK (exactly 1 cycle):
  - dbg_ack = 1; memory bus returns to core, same as CORE.
  - dbg_req is ignored in this cycle. A request still high in the following CORE cycle is a new request.
  - Next state is CORE.
- Latency: debug access with the core idle completes in 3 cycles from dbg_req rising to dbg_ack, counting the CORE decision cycle, DBG_ACC and DBG_ACK. Worst case is STARVE_LIMIT+3.
- Core penalty: at most 1 stall cycle per debug access. The core never loses a store: a stalled store is re-presented and committed in DBG_ACK or CORE.
- dbg_req=0 in CORE leaves starve_cnt unchanged.
- Reset mid-DBG_ACC: no write is issued in that cycle, the FSM returns to CORE, and dbg_ack is not pulsed.

Optional Feature:
Macro DMEM_ARB_PERF_EN.
- Defined: adds output port stall_cnt (16 bits), reset 0. It increments on every cycle with core_stall=1, saturates at 16'hFFFF, and is cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Core idle, debug write addr 0x10 data 0xDEADBEEF -> mem_WE high only in DBG_ACC; dbg_ack 2 cycles after the decision edge; no core_stall.
- Debug read 0x10 after the write -> dbg_rdata=0xDEADBEEF with dbg_ack; a subsequent core load of 0x10 returns 0xDEADBEEF.
- core_req held 1 continuously, dbg_req=1, STARVE_LIMIT=8 -> DBG_ACC entered after starve_cnt reaches 8; core_stall=1 for exactly 1 cycle; starve_cnt back to 0.
- Core store 0x20/0x1234 stalled by DBG_ACC -> memory holds 0x1234 at 0x20 after the store is re-presented; the debug access to 0x24 is unaffected.
- RST=0 during DBG_ACC of a debug write to 0x30 -> mem_WE=0, 0x30 unchanged, state CORE, no dbg_ack.
- With DMEM_ARB_PERF_EN, three preempting debug accesses under continuous core_req -> stall_cnt=3.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core MEM stage and a debug/loader port.
// Debug access takes 3 cycles when the core is idle (decide, access, ack) and at most STARVE_LIMIT+3 when it is busy.
// The core is stalled for the single DBG_ACC cycle only; debug holds dbg_req until it sees the one-cycle dbg_ack.
// Optional build macro DMEM_ARB_PERF_EN adds a saturating 16-bit stall_cnt output.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_WE,
    output logic [ADDR_WIDTH-1:0] mem_Address,
    output logic [DATA_WIDTH-1:0] mem_WD,
    input  logic [DATA_WIDTH-1:0] mem_RD
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        CORE    = 2'd0,
        DBG_ACC = 2'd1,
        DBG_ACK = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  starve_cnt_q, starve_cnt_d;
    logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
    logic                  dbg_sel;

    // Debug owns the bus only in DBG_ACC and never while reset is asserted,
    // so a reset landing mid-access cannot issue the debug write.
    assign dbg_sel = RST && (state_q == DBG_ACC);

    // Next-state, starvation counter and debug read-data capture.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        dbg_rdata_d  = dbg_rdata_q;
        case (state_q)
            CORE: begin
                if (dbg_req && core_req && (starve_cnt_q != CNT_MAX)) begin
                    starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
                end
                if (dbg_req && (!core_req || (starve_cnt_q >= LIMIT))) begin
                    state_d = DBG_ACC;
                end
            end
            DBG_ACC: begin
                // Reads capture memory data; writes leave the last read value in place.
                if (!dbg_we) begin
                    dbg_rdata_d = mem_RD;
                end
                starve_cnt_d = '0;
                state_d      = DBG_ACK;
            end
            // dbg_req is deliberately ignored here; a still-high request is a new one.
            DBG_ACK: state_d = CORE;
            default: state_d = CORE;
        endcase
    end

    // Memory bus mux, core stall and write enable; core is the default owner.
    always_comb begin
        mem_Address = core_addr;
        mem_WD      = core_wdata;
        mem_WE      = 1'b0;
        core_stall  = 1'b0;
        if (dbg_sel) begin
            mem_Address = dbg_addr;
            mem_WD      = dbg_wdata;
            mem_WE      = dbg_we;
            core_stall  = core_req;
        end else if (RST) begin
            mem_WE = core_req & core_we;
        end
    end

    assign core_rdata = mem_RD;
    assign dbg_ack    = RST && (state_q == DBG_ACK);
    assign dbg_rdata  = dbg_rdata_q;

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= CORE;
            starve_cnt_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of core stall cycles, cleared only by reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (core_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // Performance counter not built; no extra state or ports.
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter with a small word-addressed memory behind the bus.
// Debug completions are checked by a scoreboard monitor (read data and latency).
// Directed checks cover reset, stalls, write enables and memory contents.
module tb_dmem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack;
    logic        mem_WE;
    logic [31:0] mem_Address, mem_WD, mem_RD;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] stall_cnt;
`endif

    always #5 CLK = ~CLK;

    dmem_port_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(8),
        .CNT_WIDTH   (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .mem_WE     (mem_WE),
        .mem_Address(mem_Address),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
`ifdef DMEM_ARB_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // Data memory: combinational read, write on rising edge, bench-controlled clear.
    logic [31:0] mem [0:63];
    logic        mem_clr;
    assign mem_RD = mem[mem_Address[7:2]];

    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (mem_WE) begin
            mem[mem_Address[7:2]] <= mem_WD;
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        int          start;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];

    // Monitor: every dbg_ack must match exactly one outstanding expectation.
    initial begin
        forever begin
            @(negedge CLK);
            if (dbg_ack) begin
                exp_t e;
                check("ack_outstanding", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check({e.name, "_rdata"}, dbg_rdata, e.rdata);
                    check({e.name, "_latency"}, 32'(cyc - e.start + 1), 32'(e.lat));
                end
            end
        end
    end

    // Issue one debug access, hold it until ack, count write-enable and stall cycles.
    task automatic dbg_access(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input int exp_lat, input int exp_wes, input int exp_stalls);
        exp_t e;
        int   wes    = 0;
        int   stalls = 0;
        bit   got    = 1'b0;
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
        e.rdata = exp_rdata;
        e.start = cyc;
        e.lat   = exp_lat;
        e.name  = name;
        sb.push_back(e);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (mem_WE) wes++;
            if (core_stall) stalls++;
            if (dbg_ack) got = 1'b1;
            @(posedge CLK);
            #1;
        end
        dbg_req = 1'b0;
        dbg_we  = 1'b0;
        check({name, "_acked"}, 32'(got), 32'd1);
        if (!got) sb.delete();
        if (exp_wes >= 0) check({name, "_we_cycles"}, 32'(wes), 32'(exp_wes));
        check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    endtask

    initial begin
        int acks;
        // Reset with a core store presented: it must not reach memory.
        RST        = 1'b0;
        mem_clr    = 1'b1;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h44;
        core_wdata = 32'h99;
        dbg_req    = 1'b0;
        dbg_we     = 1'b0;
        dbg_addr   = 32'h0;
        dbg_wdata  = 32'h0;
        @(posedge CLK);
        #1;
        mem_clr = 1'b0;
        @(negedge CLK);
        check("rst_mem_we", 32'(mem_WE), 32'd0);
        check("rst_mem_addr", mem_Address, 32'h44);
        check("rst_core_stall", 32'(core_stall), 32'd0);
        check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'h0);
        @(posedge CLK);
        #1;
        check("rst_no_store", mem[17], 32'h0);
        RST      = 1'b1;
        core_req = 1'b0;
        core_we  = 1'b0;

        // Core idle: debug write then read back.
        dbg_access("t1_wr", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 3, 1, 0);
        check("t1_mem_0x10", mem[4], 32'hDEADBEEF);
        dbg_access("t2_rd", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 0, 0);

        // Core load sees the debug-written word.
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h10;
        @(negedge CLK);
        check("t2_core_load", core_rdata, 32'hDEADBEEF);
        check("t2_core_load_we", 32'(mem_WE), 32'd0);
        @(posedge CLK);
        #1;

        // Continuous core loads: debug waits for the starvation limit, twice in a row.
        core_addr = 32'h0;
        dbg_access("t3_rd_a", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 11, 0, 1);
        dbg_access("t3_rd_b", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 11, 0, 1);

        // Continuous core store to 0x20 while debug writes 0x24; dbg_rdata holds on writes.
        core_we    = 1'b1;
        core_addr  = 32'h20;
        core_wdata = 32'h1234;
        dbg_access("t4_wr", 1'b1, 32'h24, 32'h5555AAAA, 32'hDEADBEEF, 11, -1, 1);
        core_req = 1'b0;
        core_we  = 1'b0;
        @(posedge CLK);
        #1;
        check("t4_mem_0x20", mem[8], 32'h1234);
        check("t4_mem_0x24", mem[9], 32'h5555AAAA);
`ifdef DMEM_ARB_PERF_EN
        check("perf_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

        // Reset during DBG_ACC of a debug write to 0x30.
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 32'h30;
        dbg_wdata = 32'hCAFEF00D;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("t5_rst_mem_we", 32'(mem_WE), 32'd0);
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        dbg_req = 1'b0;
        dbg_we  = 1'b0;
        acks    = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (dbg_ack) acks++;
            @(posedge CLK);
            #1;
        end
        check("t5_no_ack", 32'(acks), 32'd0);
        check("t5_mem_0x30", mem[12], 32'h0);
`ifdef DMEM_ARB_PERF_EN
        check("perf_stall_cnt_rst", 32'(stall_cnt), 32'd0);
`endif
        dbg_access("t5_rd", 1'b0, 32'h30, 32'h0, 32'h0, 3, 0, 0);
        dbg_access("t6_rd", 1'b0, 32'h24, 32'h0, 32'h5555AAAA, 3, 0, 0);

        repeat (3) @(posedge CLK);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
